// File: rtl/rv32_fetch_unit_pkg.sv
// rtl/rv32_fetch_unit_pkg.sv - shared RV32 constants, fetch entry type and PC helpers
package rv32_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_ALIGN_MASK = 32'h0000_0003;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return |(pc & INSTR_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// rtl/rv32_fetch_unit_if.sv - fetch unit bus: imem request/response, instr stream, redirect
interface rv32_fetch_unit_if;
    import rv32_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/rv32_fetch_unit_fetch_fifo.sv
// rtl/rv32_fetch_unit_fetch_fifo.sv - prefetch FIFO of {instr, pc} with flush and count
// Head is zero whenever empty so the stream outputs read as zero when idle.
module fetch_fifo
    import rv32_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    output fetch_entry_t o_rdata,
    output logic         o_valid,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_valid = (r_count != '0);
    assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

    // Upstream credit must keep a push into a full FIFO paired with a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/rv32_fetch_unit.sv
// rtl/rv32_fetch_unit.sv - RV32I fetch stage: credit-limited imem requests, prefetch FIFO, redirects
// Wrong-path responses still owed by memory are tracked in a discard counter and dropped on arrival.
module rv32_fetch_unit
    import rv32_fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    rv32_fetch_unit_if.master fetch_bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = CW + 4;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [DW-1:0]   r_discard;
    logic            r_fault;

    logic [CW-1:0]   w_count;
    logic            w_head_valid;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;
    logic            w_credit;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_rsp_good;
    logic            w_redirect;
    logic            w_push;
    logic            w_pop;

    assign w_redirect = fetch_bus.redirect_valid;

    // Credit uses registered occupancy, so a pop frees its slot one cycle later.
    assign w_credit    = ({1'b0, w_count} + {1'b0, r_inflight}) < DEPTH_W;
    assign w_req_valid = !rst && !r_fault && !w_redirect && w_credit;
    assign w_req_fire  = w_req_valid && fetch_bus.imem_req_ready;

    assign w_rsp_drop = fetch_bus.imem_rsp_valid && (r_discard != '0);
    assign w_rsp_good = fetch_bus.imem_rsp_valid && (r_discard == '0);

    assign w_push  = w_rsp_good && !w_redirect;
    assign w_pop   = w_head_valid && fetch_bus.instr_ready && !w_redirect;
    assign w_wdata = '{instr: fetch_bus.imem_rsp_data, pc: r_rsp_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_fault    <= 1'b0;
        end else if (w_redirect) begin
            r_inflight <= '0;
            r_discard  <= r_discard + DW'(r_inflight) - DW'(fetch_bus.imem_rsp_valid);
            if (pc_misaligned(fetch_bus.redirect_pc)) begin
                r_fault <= 1'b1;
            end else begin
                r_fault    <= 1'b0;
                r_fetch_pc <= fetch_bus.redirect_pc;
                r_rsp_pc   <= fetch_bus.redirect_pc;
            end
        end else begin
            if (w_req_fire) r_fetch_pc <= next_pc(r_fetch_pc);
            if (w_rsp_good) r_rsp_pc <= next_pc(r_rsp_pc);
            if (w_rsp_drop) r_discard <= r_discard - DW'(1);
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_good);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    assign fetch_bus.imem_req_valid = w_req_valid;
    assign fetch_bus.imem_req_addr  = r_fetch_pc;
    assign fetch_bus.instr_valid    = w_head_valid;
    assign fetch_bus.instr          = w_head.instr;
    assign fetch_bus.instr_pc       = w_head.pc;
    assign fetch_bus.fetch_fault    = r_fault;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb/tb_rv32_fetch_unit.sv - scoreboard bench for rv32_fetch_unit with a fixed-latency imem model
module tb_rv32_fetch_unit;
    import rv32_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lat = 1;

    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    mreq_t       mq[$];
    logic [31:0] mon_pc;
    logic [31:0] t2_addr;

    always #5 clk = ~clk;

    rv32_fetch_unit_if bus();

    rv32_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        bus.instr_ready = 1'b0;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Memory: accepts sampled mid-cycle, response driven exactly lat cycles later.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
                acc_log.push_back(bus.imem_req_addr);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got pc %h expected none", bus.instr_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                check("instr_pc", bus.instr_pc, mon_pc);
                check("instr_data", bus.instr, mem_word(mon_pc));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        step(2);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);

        // Streaming at L=1: first instr visible in the third cycle, then one per cycle.
        push_seq(32'h0, 8);
        bus.instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t1_req_addr", bus.imem_req_addr, 32'h0);
        tick();
        check("t1_latency", 32'(bus.instr_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t1_stream_valid", 32'(bus.instr_valid), 32'd1);
            tick();
        end
        bus.instr_ready = 1'b0;
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: credit stops after DEPTH requests, resumes at 0x10.
        rst = 1'b1;
        acc_log.delete();
        step(2);
        rst = 1'b0;
        step(12);
        check("t2_req_count", 32'(acc_log.size()), 32'd4);
        check("t2_req_held", 32'(bus.imem_req_valid), 32'd0);
        push_seq(32'h0, 8);
        bus.instr_ready = 1'b1;
        wait_drain(60, "t2_drain");
        t2_addr = (acc_log.size() > 4) ? acc_log[4] : 32'hFFFF_FFFF;
        check("t2_resume_addr", t2_addr, 32'h10);

        // L=3, redirect with two buffered and two in flight.
        rst = 1'b1;
        lat = 3;
        step(2);
        rst = 1'b0;
        step(5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        check("t3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        push_seq(32'h100, 6);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("t3_post_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("t3_post_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t3_post_req_addr", bus.imem_req_addr, 32'h100);
        bus.instr_ready = 1'b1;
        wait_drain(100, "t3_drain");

        // Misaligned redirect faults and blocks fetch until an aligned one.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_fault_set", 32'(bus.fetch_fault), 32'd1);
        check("t4_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        step(5);
        check("t4_fault_hold", 32'(bus.fetch_fault), 32'd1);
        check("t4_req_hold", 32'(bus.imem_req_valid), 32'd0);
        check("t4_instr_idle", 32'(bus.instr_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        push_seq(32'h200, 4);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_fault_clear", 32'(bus.fetch_fault), 32'd0);
        check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t4_req_addr", bus.imem_req_addr, 32'h200);
        bus.instr_ready = 1'b1;
        wait_drain(80, "t4_drain");

        // Address wrap at the top of the space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        tick();
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        wait_drain(80, "t5_drain");

        // Reset mid-stream with memory stalled.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        bus.redirect_valid = 1'b0;
        step(6);
        check("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
        bus.imem_req_ready = 1'b0;
        step(2);
        #1;
        rst = 1'b1;
        #1;
        check("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t6_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_instr", bus.instr, 32'd0);
        check("t6_instr_pc", bus.instr_pc, 32'd0);
        check("t6_fault", 32'(bus.fetch_fault), 32'd0);
        lat = 1;
        step(2);
        bus.imem_req_ready = 1'b1;
        push_seq(32'h0, 3);
        bus.instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("t6_refetch_addr", bus.imem_req_addr, 32'h0);
        wait_drain(40, "t6_drain");

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
